fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 130 +++++++++++++
 tb/tb_fetch_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: IDLE/FETCH/HOLD instruction fetch sequencer steering an external PC and memory.
// Define FETCH_SEQ_RAS_EN to build a 4-entry return-address stack for call_req/ret_req.
module fetch_seq #(
  parameter int W = 15
) (
  input  logic         clk50m,
  input  logic         rst_n,
  input  logic         halt,
  input  logic [W-1:0] pc,
  output logic         pc_en,
  output logic         pc_inc,
  output logic         pc_load,
  output logic [W-1:0] pc_load_val,
  output logic         mem_req,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [15:0]  mem_rdata,
  output logic [15:0]  instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jmp_req,
  input  logic [W-1:0] jmp_addr,
  input  logic         call_req,
  input  logic         ret_req,
  output logic         ras_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t       state;
  logic         fetch_done;
  logic         accept;
  logic         load_now;
  logic [W-1:0] load_target;

  assign fetch_done  = (state == FETCH) && mem_ack;
  assign accept      = (state == HOLD) && instr_valid && instr_ready;

  // Increment happens only in FETCH and loads only in HOLD, so the two can never overlap.
  assign mem_req     = (state == FETCH);
  assign mem_addr    = mem_req ? pc : '0;
  assign pc_inc      = fetch_done;
  assign pc_load     = load_now;
  assign pc_load_val = load_now ? load_target : '0;
  assign pc_en       = pc_inc | pc_load;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) state <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= halt ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_SEQ_RAS_EN
  logic [W-1:0] ras_mem [4];
  logic [1:0]   ras_ptr;
  logic [2:0]   ras_cnt;
  logic [1:0]   top_idx;
  logic         ras_empty;
  logic         do_ret;
  logic         do_call;

  // ras_ptr is the next write slot; when the stack is full it also points at the oldest entry.
  assign top_idx   = ras_ptr - 2'd1;
  assign ras_empty = (ras_cnt == 3'd0);
  assign do_ret    = accept && ret_req;
  assign do_call   = accept && call_req && !ret_req;

  always_comb begin
    load_now    = 1'b0;
    load_target = '0;
    if (do_ret) begin
      load_now    = 1'b1;
      load_target = ras_empty ? '0 : ras_mem[top_idx];
    end else if (accept && (call_req || jmp_req)) begin
      load_now    = 1'b1;
      load_target = jmp_addr;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= 2'd0;
      ras_cnt <= 3'd0;
      ras_err <= 1'b0;
      for (int i = 0; i < 4; i++) ras_mem[i] <= '0;
    end else if (do_ret) begin
      if (ras_empty) begin
        ras_err <= 1'b1;
      end else begin
        ras_ptr <= top_idx;
        ras_cnt <= ras_cnt - 3'd1;
      end
    end else if (do_call) begin
      ras_mem[ras_ptr] <= pc;
      ras_ptr          <= ras_ptr + 2'd1;
      if (ras_cnt != 3'd4) ras_cnt <= ras_cnt + 3'd1;
    end
  end
`else
  logic unused_ras;

  assign load_now    = accept && jmp_req;
  assign load_target = jmp_addr;
  assign ras_err     = 1'b0;
  assign unused_ras  = call_req ^ ret_req;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized bench for fetch_seq with a transaction-level fetch/stack model.
// Compile with +define+FETCH_SEQ_RAS_EN to also exercise the return-address stack.
module tb_fetch_seq;

  localparam int W          = 15;
  localparam int MODE_RAND  = 0;
  localparam int MODE_CALL  = 1;
  localparam int MODE_RET   = 2;
  localparam int MODE_NONE  = 3;
  localparam int MODE_JMP   = 4;

  logic         clk50m = 1'b0;
  logic         rst_n;
  logic         halt;
  logic [W-1:0] pc;
  logic         pc_en, pc_inc, pc_load;
  logic [W-1:0] pc_load_val;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [15:0]  mem_rdata;
  logic [15:0]  instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         jmp_req;
  logic [W-1:0] jmp_addr;
  logic         call_req, ret_req;
  logic         ras_err;

  logic [W-1:0] pc_start;

  int checks = 0;
  int errors = 0;

  // Reference model state: next address to fetch, last fetched address, pending handshake obligations.
  logic         exp_req, exp_valid, model_err;
  logic [W-1:0] model_next, model_fetched;
  logic [W-1:0] ras_q[$];
  int           accepts = 0;

  fetch_seq #(.W(W)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .halt(halt), .pc(pc),
    .pc_en(pc_en), .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jmp_req(jmp_req), .jmp_addr(jmp_addr), .call_req(call_req), .ret_req(ret_req),
    .ras_err(ras_err)
  );

  always #5 clk50m = ~clk50m;

  // Program counter living outside the sequencer.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) pc <= pc_start;
    else if (pc_en) begin
      if (pc_load) pc <= pc_load_val;
      else if (pc_inc) pc <= pc + 1'b1;
    end
  end

  function automatic logic [15:0] mem_word(input logic [W-1:0] a);
    return {a, 1'b1} ^ 16'h5a3c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [W-1:0] start);
    exp_req    = 1'b0;
    exp_valid  = 1'b0;
    model_err  = 1'b0;
    model_next = start;
    model_fetched = '0;
    ras_q.delete();
  endtask

  task automatic applyStimulus(input int ready_pct, input int ack_pct, input int halt_pct, input int mode);
    logic         acc, exp_load, err_next;
    logic [W-1:0] tgt, nxt;
    @(negedge clk50m);
    halt        = ($urandom_range(99) < halt_pct);
    instr_ready = ($urandom_range(99) < ready_pct);
    mem_ack     = mem_req && ($urandom_range(99) < ack_pct);
    mem_rdata   = mem_ack ? mem_word(mem_addr) : 16'($urandom);
    jmp_addr    = W'($urandom);
    jmp_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
    case (mode)
      MODE_RAND: begin
        jmp_req  = ($urandom_range(99) < 25);
        call_req = ($urandom_range(99) < 15);
        ret_req  = ($urandom_range(99) < 15);
      end
      MODE_CALL: begin call_req = 1'b1; jmp_addr = W'(model_next + 9); end
      MODE_RET:  ret_req = 1'b1;
      MODE_JMP:  begin jmp_req = 1'b1; jmp_addr = 15'h0100; end
      default: ;
    endcase
    #1;
    checkOutput("excl", pc_inc & pc_load, 0);
    checkOutput("pc_en", pc_en, pc_inc | pc_load);
    if (!pc_load) checkOutput("ldval_idle", pc_load_val, 0);
    checkOutput("mem_req", mem_req, exp_req);
    checkOutput("instr_valid", instr_valid, exp_valid);
    if (exp_req) checkOutput("mem_addr", mem_addr, model_next);
    else checkOutput("mem_addr_idle", mem_addr, 0);
    checkOutput("pc_inc", pc_inc, exp_req && mem_ack);
    checkOutput("ras_err", ras_err, model_err);
    if (exp_valid) begin
      nxt = model_fetched + 1'b1;
      checkOutput("pc_hold", pc, nxt);
      checkOutput("instr", instr, mem_word(model_fetched));
    end

    acc = exp_valid && instr_ready;
    exp_load = 1'b0; tgt = '0; err_next = model_err;
    if (acc) begin
`ifdef FETCH_SEQ_RAS_EN
      if (ret_req) begin
        exp_load = 1'b1;
        if (ras_q.size() > 0) tgt = ras_q.pop_back();
        else begin tgt = '0; err_next = 1'b1; end
      end else if (call_req) begin
        exp_load = 1'b1;
        tgt = jmp_addr;
        ras_q.push_back(model_next);
        if (ras_q.size() > 4) ras_q.delete(0);
      end else if (jmp_req) begin
        exp_load = 1'b1;
        tgt = jmp_addr;
      end
`else
      if (jmp_req) begin
        exp_load = 1'b1;
        tgt = jmp_addr;
      end
`endif
    end
    checkOutput("pc_load", pc_load, exp_load);
    if (exp_load) checkOutput("pc_load_val", pc_load_val, tgt);

    if (exp_req && mem_ack) begin
      model_fetched = model_next;
      model_next    = model_next + 1'b1;
      exp_req       = 1'b0;
      exp_valid     = 1'b1;
    end else if (acc) begin
      accepts++;
      exp_valid = 1'b0;
      exp_req   = !halt;
      if (exp_load) model_next = tgt;
    end else if (!exp_req && !exp_valid && !halt) begin
      exp_req = 1'b1;
    end
    model_err = err_next;
  endtask

  task automatic do_reset(input logic [W-1:0] start);
    @(negedge clk50m);
    pc_start = start;
    rst_n = 1'b0;
    halt = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    jmp_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
    model_reset(start);
    repeat (2) @(posedge clk50m);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0;
    rst_n = 1'b0; pc_start = '0; halt = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hbeef; instr_ready = 1'b1;
    jmp_req = 1'b1; jmp_addr = 15'h0005; call_req = 1'b1; ret_req = 1'b1;
    model_reset('0);
    repeat (3) @(posedge clk50m);
    @(negedge clk50m);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_pc_en", pc_en, 0);
    checkOutput("rst_pc_inc", pc_inc, 0);
    checkOutput("rst_pc_load", pc_load, 0);
    checkOutput("rst_ldval", pc_load_val, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_ras_err", ras_err, 0);
    jmp_req = 1'b0; call_req = 1'b0; ret_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk50m);
    #2 rst_n = 1'b1;

    // Sequential fetch from 0, then full-rate throughput.
    repeat (12) applyStimulus(100, 100, 0, MODE_NONE);
    a0 = accepts;
    repeat (20) applyStimulus(100, 100, 0, MODE_NONE);
    checkOutput("throughput", ((accepts - a0) >= 9) ? 1 : 0, 1);

    // Random traffic with backpressure, slow memory, halts and branches.
    a0 = accepts;
    repeat (3000) applyStimulus(60, 50, 10, MODE_RAND);
    checkOutput("progress", ((accepts - a0) >= 100) ? 1 : 0, 1);

    // Jump from 0x1e to 0x100.
    do_reset(15'h001e);
    a0 = accepts;
    for (int i = 0; i < 20 && accepts == a0; i++) applyStimulus(100, 100, 0, MODE_JMP);
    applyStimulus(100, 0, 0, MODE_NONE);
    checkOutput("jump_req", mem_req, 1);
    checkOutput("jump_addr", mem_addr, 15'h0100);

    // Wrap at the top of the address space, then park with halt.
    do_reset(15'h7ffe);
    for (int i = 0; i < 20 && !(exp_valid && model_fetched == 15'h7fff); i++)
      applyStimulus(100, 100, 0, MODE_NONE);
    applyStimulus(0, 100, 100, MODE_NONE);
    checkOutput("wrap_pc", pc, 0);
    applyStimulus(100, 100, 100, MODE_NONE);
    applyStimulus(100, 100, 100, MODE_NONE);
    checkOutput("park_req", mem_req, 0);
    checkOutput("park_valid", instr_valid, 0);

    // Reset in the middle of a fetch with a late acknowledge.
    for (int i = 0; i < 10 && !exp_req; i++) applyStimulus(100, 0, 0, MODE_NONE);
    @(negedge clk50m);
    checkOutput("fetch_reached", mem_req, 1);
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hdead;
    #1;
    checkOutput("midrst_req", mem_req, 0);
    checkOutput("midrst_addr", mem_addr, 0);
    checkOutput("midrst_pc_en", pc_en, 0);
    checkOutput("midrst_pc_inc", pc_inc, 0);
    model_reset(pc_start);
    @(posedge clk50m);
    #1;
    checkOutput("midrst_valid", instr_valid, 0);
    checkOutput("midrst_instr", instr, 0);
    mem_ack = 1'b0;
    @(posedge clk50m);
    #2 rst_n = 1'b1;
    applyStimulus(100, 0, 0, MODE_NONE);
    applyStimulus(100, 0, 0, MODE_NONE);
    checkOutput("restart_req", mem_req, 1);

`ifdef FETCH_SEQ_RAS_EN
    // Five calls overflow the 4-deep stack, five returns end in underflow.
    do_reset(15'd10);
    a0 = accepts;
    for (int i = 0; i < 200 && accepts < a0 + 5; i++) applyStimulus(100, 100, 0, MODE_CALL);
    checkOutput("call_burst", 32'(accepts - a0), 5);
    a0 = accepts;
    for (int i = 0; i < 200 && accepts < a0 + 5; i++) applyStimulus(100, 100, 0, MODE_RET);
    checkOutput("ret_burst", 32'(accepts - a0), 5);
    applyStimulus(0, 100, 0, MODE_NONE);
    checkOutput("ras_err_final", ras_err, 1);
    checkOutput("underflow_target", mem_addr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
